enb_monitor: RTL
================

Name: enb_monitor

Overview:
- Receiving-end checker for periodic single-cycle enable strobes of the kind the clock-enable generators in this design produce.
- Measures the clock-cycle spacing between successive strobe rising edges and compares it against the expected divide amount.
- Reports lock and error status, and counts errors.
- Used on-board and in benches to qualify enable sources before downstream logic trusts them.

Parameters:
- CLKFREQ, 100_000_000, system clock frequency in Hz.
- DIVFREQ, 100, expected strobe frequency in Hz.
- EXPECTED, CLKFREQ/DIVFREQ, expected period in clk cycles.
- TOL, 0, allowed deviation in cycles; a period is good when |period-EXPECTED| <= TOL.
- LOCKCNT, 4, number of consecutive good periods required to assert locked.
- CNTBITS, $clog2(2*EXPECTED+1), width of the period counter and period output.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enb_in  input  1  monitored strobe, synchronous to clk.
- period  output  CNTBITS  last measured period in cycles.
- period_valid  output  1  one-cycle pulse; period updated.
- locked  output  1  level; source is within tolerance.
- err  output  1  one-cycle pulse on a bad period or a timeout.
- timeout  output  1  level; no edge within 2*EXPECTED cycles.
- err_count  output  8  saturating error count.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high, named reset; the clock is named clk.
  - On reset, all outputs are 0, state is IDLE, and counters and the edge-detect register are cleared.
  - Reset mid-operation discards any partial measurement and clears err_count.
- Edge detection:
  - An event is a rising edge of enb_in (enb_in=1 and the previous-cycle value=0).
  - enb_in held high for N cycles produces one event.
- Period measurement:
  - For events at cycles t0 and t1, period = t1-t0.
  - period, period_valid, err and locked all update on the registered cycle t1+1 (latency 1).
  - period holds its value between updates.
- States:
  - IDLE: waits for the first event. An event starts the counter, clears timeout, gives no period_valid, and moves to ACQUIRE.
  - ACQUIRE: on each event, output the period.
    - Good period: increment the good-run counter; when it reaches LOCKCNT, go to LOCKED and set locked=1.
    - Bad period: err pulse, good-run counter reset to 0.
  - LOCKED: on each event, output the period.
    - Good period: stay in LOCKED.
    - Bad period: err pulse, locked=0, good-run counter=0, go to ACQUIRE.
- Timeout:
  - Applies in ACQUIRE or LOCKED when no event occurs through cycle t0+2*EXPECTED.
  - At t0+2*EXPECTED+1: timeout=1, a single err pulse, locked=0, good-run counter=0, go to IDLE.
  - timeout stays high until the next event.
  - The counter saturates and never wraps.
- Simultaneous events:
  - An event exactly at t0+2*EXPECTED is a measured period (2*EXPECTED), not a timeout.
  - An event on the same cycle as reset is ignored.
- err_count:
  - Increments on every err pulse.
  - Saturates at 255.
- Arithmetic: the tolerance compare uses an unsigned absolute difference, with no overflow at period=0 or period=2*EXPECTED.

Test Plan:
All scenarios use CLKFREQ=100, DIVFREQ=10 (EXPECTED=10), LOCKCNT=3, TOL=0 unless stated.
1. Nominal lock: 1-cycle pulses every 10 cycles -> first edge gives no valid; each later edge gives period=10 with period_valid one cycle later; locked=1 coincident with the 3rd period_valid; err never pulses; err_count=0.
2. Bad period while locked: one pulse arrives 9 cycles after the previous -> period=9, err pulse, locked=0, err_count=1; then three 10-cycle periods -> locked=1 again.
3. Timeout: pulses stop after locking -> timeout=1 and a single err pulse 21 cycles after the last edge, locked=0; next edge clears timeout with no period_valid; following edge gives period_valid with the measured value. Edge at exactly 20 cycles -> period=20, err, no timeout.
4. Tolerance (TOL=1): periods 9, 11, 10 -> all good, locked after the third; period 12 -> err, locked=0.
5. Held input: enb_in high for 5 cycles repeating every 10 cycles -> one event per burst, period=10 throughout.
6. Reset and saturation: assert reset mid-ACQUIRE -> all outputs 0 the next cycle; drive 300 bad periods -> err_count stops at 255.

Source files
------------

// File: rtl/enb_monitor.sv
// Receiving-end checker for periodic single-cycle enable strobes: measures the
// rising-edge spacing, compares it to EXPECTED +/- TOL, and reports lock/err/timeout.
module enb_monitor #(
  parameter int CLKFREQ  = 100_000_000,
  parameter int DIVFREQ  = 100,
  parameter int EXPECTED = CLKFREQ / DIVFREQ,
  parameter int TOL      = 0,
  parameter int LOCKCNT  = 4,
  parameter int CNTBITS  = $clog2(2*EXPECTED+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enb_in,
  output logic [CNTBITS-1:0] period,
  output logic               period_valid,
  output logic               locked,
  output logic               err,
  output logic               timeout,
  output logic [7:0]         err_count
);

  localparam int RUNBITS = (LOCKCNT < 1) ? 1 : $clog2(LOCKCNT+1);
  localparam logic [CNTBITS-1:0] EXP_C  = CNTBITS'(EXPECTED);
  localparam logic [CNTBITS-1:0] MAX_C  = CNTBITS'(2*EXPECTED);
  localparam logic [RUNBITS-1:0] LOCK_C = RUNBITS'(LOCKCNT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t               state_q, state_d;
  logic                 enb_q;
  logic [CNTBITS-1:0]   cnt_q, cnt_d;
  logic [RUNBITS-1:0]   run_q, run_d;
  logic [CNTBITS-1:0]   period_q, period_d;
  logic                 pv_q, pv_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;
  logic                 to_q, to_d;
  logic [7:0]           ecnt_q, ecnt_d;

  logic                 ev;
  logic [CNTBITS-1:0]   diff;
  logic                 good;
  logic                 expired;
  logic [RUNBITS-1:0]   run_inc;

  // cnt_q equals cycles elapsed since the last event, so at an event it is the period.
  assign ev      = enb_in & ~enb_q;
  assign diff    = (cnt_q >= EXP_C) ? (cnt_q - EXP_C) : (EXP_C - cnt_q);
  assign good    = (int'(diff) <= TOL);
  assign expired = (cnt_q == MAX_C);
  assign run_inc = run_q + RUNBITS'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      enb_q    <= 1'b0;
      cnt_q    <= '0;
      run_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
      ecnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      enb_q    <= enb_in;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      to_q     <= to_d;
      ecnt_q   <= ecnt_d;
    end
  end

  // An event landing exactly on the 2*EXPECTED cycle is a measurement, not a timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ev) state_d = ACQUIRE;
      ACQUIRE: begin
        if (ev) begin
          if (good && run_inc == LOCK_C) state_d = LOCKED;
        end else if (expired) begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (ev) begin
          if (!good) state_d = ACQUIRE;
        end else if (expired) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    run_d    = run_q;
    period_d = period_q;
    pv_d     = 1'b0;
    err_d    = 1'b0;
    to_d     = to_q;
    if (ev)                 cnt_d = CNTBITS'(1);
    else if (cnt_q != MAX_C) cnt_d = cnt_q + CNTBITS'(1);
    case (state_q)
      IDLE: if (ev) to_d = 1'b0;
      ACQUIRE, LOCKED: begin
        if (ev) begin
          period_d = cnt_q;
          pv_d     = 1'b1;
          if (!good) begin
            err_d = 1'b1;
            run_d = '0;
          end else if (state_q == ACQUIRE) begin
            run_d = run_inc;
          end
        end else if (expired) begin
          to_d  = 1'b1;
          err_d = 1'b1;
          run_d = '0;
        end
      end
      default: ;
    endcase
    locked_d = (state_d == LOCKED);
    ecnt_d   = (err_d && ecnt_q != 8'hFF) ? ecnt_q + 8'd1 : ecnt_q;
  end

  assign period       = period_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign err          = err_q;
  assign timeout      = to_q;
  assign err_count    = ecnt_q;

endmodule
